// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - iterative packed-BCD to binary converter (reverse double-dabble)
module bcd_to_binary_seq #(
  parameter int numberOfDigits = 4,
  parameter int binWidth       = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic [4*numberOfDigits-1:0] bcdIn,
  input  logic                        inValid,
  output logic                        inReady,
  output logic [binWidth-1:0]         binOut,
  output logic                        digitErr,
  output logic                        outValid,
  input  logic                        outReady
);

  localparam int BcdW = 4 * numberOfDigits;
  localparam int CntW = $clog2(binWidth + 1);
  localparam logic [CntW-1:0] LastCount = CntW'(binWidth);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [BcdW-1:0]      bcd_reg;
  logic [binWidth-1:0]  bin_reg;
  logic [CntW-1:0]      count;
  logic                 accept;
  logic                 digit_bad;
  logic [BcdW-1:0]      shifted_bcd;
  logic [BcdW-1:0]      adj_bcd;
  logic [binWidth-1:0]  shifted_bin;

  assign inReady  = (state == IDLE) && ena;
  assign accept   = inValid && inReady;
  assign outValid = (state == DONE);

  always_comb begin
    digit_bad = 1'b0;
    for (int d = 0; d < numberOfDigits; d++) begin
      if (bcdIn[4*d +: 4] > 4'd9) digit_bad = 1'b1;
    end
  end

  // One reverse-dabble step: shift right, then pull every digit that went >= 8 back by 3.
  always_comb begin
    shifted_bcd = {1'b0, bcd_reg[BcdW-1:1]};
    shifted_bin = {bcd_reg[0], bin_reg[binWidth-1:1]};
    adj_bcd     = shifted_bcd;
    for (int d = 0; d < numberOfDigits; d++) begin
      if (shifted_bcd[4*d +: 4] >= 4'd8) adj_bcd[4*d +: 4] = shifted_bcd[4*d +: 4] - 4'd3;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = digit_bad ? DONE : CONVERT;
      CONVERT: if (count == LastCount) state_next = DONE;
      DONE:    if (outReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bcd_reg  <= '0;
      bin_reg  <= '0;
      count    <= '0;
      binOut   <= '0;
      digitErr <= 1'b0;
    end else if (ena) begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            bcd_reg <= bcdIn;
            bin_reg <= '0;
            count   <= '0;
            if (digit_bad) begin
              binOut   <= '0;
              digitErr <= 1'b1;
            end
          end
        end
        CONVERT: begin
          if (count == LastCount) begin
            binOut   <= bin_reg;
            digitErr <= 1'b0;
          end else begin
            bcd_reg <= adj_bcd;
            bin_reg <= shifted_bin;
            count   <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb/tb_bcd_to_binary_seq.sv - scoreboard bench for bcd_to_binary_seq
module tb_bcd_to_binary_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [15:0] bcdIn;
  logic        inValid;
  logic        inReady;
  logic [13:0] binOut;
  logic        digitErr;
  logic        outValid;
  logic        outReady;

  bcd_to_binary_seq #(.numberOfDigits(4), .binWidth(14)) dut (
    .clk(clk), .rst(rst), .ena(ena), .bcdIn(bcdIn), .inValid(inValid), .inReady(inReady),
    .binOut(binOut), .digitErr(digitErr), .outValid(outValid), .outReady(outReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] bin;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_edge = 0;
  int   rise_edge = 0;
  bit   sweep_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic exp_t ref_model(input logic [15:0] b);
    exp_t r;
    int   n = 0;
    r.err = 1'b0;
    for (int d = 3; d >= 0; d--) begin
      if (b[4*d +: 4] > 4'd9) r.err = 1'b1;
      n = n * 10 + int'(b[4*d +: 4]);
    end
    r.bin = r.err ? 14'd0 : 14'(n);
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] b;
    b[3:0]   = 4'(n % 10);
    b[7:4]   = 4'((n / 10) % 10);
    b[11:8]  = 4'((n / 100) % 10);
    b[15:12] = 4'((n / 1000) % 10);
    return b;
  endfunction

  // Monitor: a transfer happens at the next edge whenever this condition holds at the negedge.
  always @(negedge clk) begin
    if (!rst && outValid && outReady && ena) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("binOut", 32'(binOut), 32'(e.bin));
        chk("digitErr", 32'(digitErr), 32'(e.err));
        if (!e.err) chk("bcd_reg_drained", 32'(dut.bcd_reg), 32'd0);
      end
    end
  end

  task automatic send(input logic [15:0] v);
    bit got = 0;
    bcdIn   = v;
    inValid = 1'b1;
    for (int t = 0; t < 600 && !got; t++) begin
      @(negedge clk);
      if (inValid && inReady && !rst) begin
        got = 1;
        sb.push_back(ref_model(v));
        acc_edge = cyc + 1;
      end
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
    bcdIn   = 16'($urandom);
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid();
    bit seen = 0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (outValid) begin
        seen = 1;
        rise_edge = cyc;
      end
    end
    if (!seen) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int t = 0; t < 2000 && !idle; t++) begin
      @(negedge clk);
      if (!outValid && sb.size() == 0) idle = 1;
    end
    if (!idle) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_latency(input logic [15:0] v, input int lat, input string name);
    send(v);
    wait_valid();
    chk(name, 32'(rise_edge - acc_edge), 32'(lat));
    wait_idle();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_v;
    rst = 1'b1; ena = 1'b1; inValid = 1'b0; outReady = 1'b1; bcdIn = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outValid", 32'(outValid), 32'd0);
    chk("reset_binOut", 32'(binOut), 32'd0);
    chk("reset_digitErr", 32'(digitErr), 32'd0);
    chk("reset_inReady", 32'(inReady), 32'd1);
    @(posedge clk); #1;

    run_latency(16'h0000, 15, "lat_zero");
    run_latency(16'h9999, 15, "lat_9999");
    run_latency(16'h1234, 15, "lat_1234");

    // Bad digit: result is presented in the cycle right after the accept edge.
    run_latency(16'h12A4, 0, "lat_err");
    run_latency(16'h0042, 15, "lat_0042");

    // Consumer back-pressure in DONE.
    outReady = 1'b0;
    send(16'h0857);
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("hold_binOut", 32'(binOut), 32'd857);
      chk("hold_outValid", 32'(outValid), 32'd1);
      chk("hold_inReady", 32'(inReady), 32'd0);
    end
    @(posedge clk); #1 outReady = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_inReady", 32'(inReady), 32'd1);
    chk("release_outValid", 32'(outValid), 32'd0);
    @(posedge clk); #1;

    // Clock-enable stall.
    ena = 1'b0;
    @(negedge clk);
    chk("stall_idle_inReady", 32'(inReady), 32'd0);
    @(posedge clk); #1 ena = 1'b1;
    send(16'h0500);
    repeat (4) @(posedge clk);
    #1 ena = 1'b0;
    repeat (3) @(posedge clk);
    #1 ena = 1'b1;
    wait_valid();
    chk("lat_stall", 32'(rise_edge - acc_edge), 32'd18);
    wait_idle();

    // Reset part-way through a conversion.
    send(16'h4321);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    seen_v = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (outValid) seen_v = 1;
    end
    chk("abort_no_valid", 32'(seen_v), 32'd0);
    chk("abort_binOut", 32'(binOut), 32'd0);
    chk("abort_idle", 32'(inReady), 32'd1);
    @(posedge clk); #1;
    run_latency(16'h4321, 15, "lat_after_abort");

    // Random sweep with ena / outReady / inValid gaps.
    fork
      begin
        send(to_bcd(0));
        send(to_bcd(9999));
        for (int i = 0; i < 1500; i++) begin
          logic [15:0] v;
          if ($urandom_range(0, 7) == 0) v = 16'($urandom);
          else v = to_bcd(int'($urandom_range(0, 9999)));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send(v);
        end
        wait_idle();
        sweep_done = 1;
      end
      begin
        while (!sweep_done) begin
          @(posedge clk);
          #1;
          if (!sweep_done) begin
            ena      = ($urandom_range(0, 9) != 0);
            outReady = ($urandom_range(0, 3) != 0);
          end
        end
      end
    join
    ena = 1'b1;
    outReady = 1'b1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
